dmi_txn_guard: RTL and testbench

Single-outstanding DMI transaction guard between the DMI master (JTAG tap or socket-driven DMI source) and the debug module. It forwards each request and returns the matching response. A non-responding debug module is bounded by a response timeout that synthesizes an error response. Late responses from timed-out transactions are swallowed so they are never mis-associated with a later request.

---
 rtl/dmi_txn_guard.sv | 154 +++++++++++++++
 tb/tb_dmi_txn_guard.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_txn_guard.sv
// DMI guard: one request in flight, response timeout synthesizes an error, late replies are swallowed.
// Latency: 3-cycle minimum round trip; backpressure: requests and responses held stable until accepted, no timeout while issuing.
module dmi_txn_guard #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        up_req_valid,
    output logic        up_req_ready,
    input  logic [6:0]  up_req_addr,
    input  logic [31:0] up_req_data,
    input  logic [1:0]  up_req_op,
    output logic        up_rsp_valid,
    input  logic        up_rsp_ready,
    output logic [31:0] up_rsp_data,
    output logic [1:0]  up_rsp_response,
    output logic        dm_req_valid,
    input  logic        dm_req_ready,
    output logic [6:0]  dm_req_addr,
    output logic [31:0] dm_req_data,
    output logic [1:0]  dm_req_op,
    input  logic        dm_rsp_valid,
    output logic        dm_rsp_ready,
    input  logic [31:0] dm_rsp_data,
    input  logic [1:0]  dm_rsp_response,
    output logic        busy,
    output logic        stale,
    output logic [15:0] timeout_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        RESP     = 2'd3
    } state_t;

    typedef struct packed {
        logic [6:0]  addr;
        logic [31:0] data;
        logic [1:0]  op;
    } req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  response;
    } rsp_t;

    localparam logic [1:0]  OP_RSVD    = 2'd3;
    localparam logic [1:0]  RSP_FAILED = 2'd2;
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 32'd1);

    state_t      state_q, state_d;
    req_t        req_q, req_d;
    rsp_t        rsp_q, rsp_d;
    logic [15:0] timer_q, timer_d;
    logic        stale_q, stale_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    logic up_req_fire;
    logic dm_req_fire;
    logic dm_rsp_fire;
    logic up_rsp_fire;

    // Ready signals are the only state-decoded outputs allowed to see RST_N directly.
    assign up_req_ready    = (state_q == IDLE) && RST_N;
    assign dm_req_valid    = (state_q == ISSUE) && !stale_q;
    assign dm_rsp_ready    = (state_q == WAIT_RSP) || stale_q;
    assign up_rsp_valid    = (state_q == RESP);
    assign up_rsp_data     = rsp_q.data;
    assign up_rsp_response = rsp_q.response;
    assign dm_req_addr     = req_q.addr;
    assign dm_req_data     = req_q.data;
    assign dm_req_op       = req_q.op;
    assign busy            = (state_q != IDLE);
    assign stale           = stale_q;
    assign timeout_count   = tmo_cnt_q;

    assign up_req_fire = up_req_valid && up_req_ready;
    assign dm_req_fire = dm_req_valid && dm_req_ready;
    assign dm_rsp_fire = dm_rsp_valid && dm_rsp_ready;
    assign up_rsp_fire = up_rsp_valid && up_rsp_ready;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        rsp_d     = rsp_q;
        timer_d   = timer_q;
        stale_d   = stale_q;
        tmo_cnt_d = tmo_cnt_q;

        // A stale reply can only land outside WAIT_RSP, so it never competes with a capture.
        if (stale_q && dm_rsp_valid) begin
            stale_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (up_req_fire) begin
                    req_d = {up_req_addr, up_req_data, up_req_op};
                    if (up_req_op == OP_RSVD) begin
                        rsp_d   = {32'd0, RSP_FAILED};
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (dm_req_fire) begin
                    timer_d = 16'd0;
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                timer_d = timer_q + 16'd1;
                if (dm_rsp_fire) begin
                    rsp_d   = {dm_rsp_data, dm_rsp_response};
                    state_d = RESP;
                end else if (timer_q == TMO_LAST) begin
                    rsp_d     = {32'd0, RSP_FAILED};
                    stale_d   = 1'b1;
                    tmo_cnt_d = (tmo_cnt_q == 16'hFFFF) ? tmo_cnt_q : tmo_cnt_q + 16'd1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (up_rsp_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            req_q     <= '0;
            rsp_q     <= '0;
            timer_q   <= '0;
            stale_q   <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            rsp_q     <= rsp_d;
            timer_q   <= timer_d;
            stale_q   <= stale_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_dmi_txn_guard.sv
// Bench for dmi_txn_guard: transaction-level reference model, per-cycle compare, directed and random traffic.
module tb_dmi_txn_guard;

    localparam int T = 8;

    logic        CLK   = 1'b0;
    logic        RST_N = 1'b0;
    logic        up_req_valid = 1'b0;
    logic [6:0]  up_req_addr  = '0;
    logic [31:0] up_req_data  = '0;
    logic [1:0]  up_req_op    = '0;
    logic        up_rsp_ready = 1'b0;
    logic        dm_req_ready = 1'b0;
    logic        dm_rsp_valid = 1'b0;
    logic [31:0] dm_rsp_data  = '0;
    logic [1:0]  dm_rsp_response = '0;

    logic        up_req_ready;
    logic        up_rsp_valid;
    logic [31:0] up_rsp_data;
    logic [1:0]  up_rsp_response;
    logic        dm_req_valid;
    logic [6:0]  dm_req_addr;
    logic [31:0] dm_req_data;
    logic [1:0]  dm_req_op;
    logic        dm_rsp_ready;
    logic        busy;
    logic        stale;
    logic [15:0] timeout_count;

    always #5 CLK = ~CLK;

    dmi_txn_guard #(.TIMEOUT_CYCLES(T)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .up_req_valid(up_req_valid), .up_req_ready(up_req_ready),
        .up_req_addr(up_req_addr), .up_req_data(up_req_data), .up_req_op(up_req_op),
        .up_rsp_valid(up_rsp_valid), .up_rsp_ready(up_rsp_ready),
        .up_rsp_data(up_rsp_data), .up_rsp_response(up_rsp_response),
        .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
        .dm_req_addr(dm_req_addr), .dm_req_data(dm_req_data), .dm_req_op(dm_req_op),
        .dm_rsp_valid(dm_rsp_valid), .dm_rsp_ready(dm_rsp_ready),
        .dm_rsp_data(dm_rsp_data), .dm_rsp_response(dm_rsp_response),
        .busy(busy), .stale(stale), .timeout_count(timeout_count)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction record plus the debug-module debt, advanced per edge.
    int          cyc = 0;
    bit          m_active = 0, m_issued = 0, m_have_rsp = 0, m_stale = 0;
    int          m_issue_cyc = 0;
    int          m_tmo = 0;
    logic [6:0]  m_req_addr = '0;
    logic [31:0] m_req_data = '0;
    logic [1:0]  m_req_op = '0;
    logic [31:0] m_rsp_data = '0;
    logic [1:0]  m_rsp_resp = '0;

    // Emulated debug module: answers each accepted request after plan_delay cycles.
    int          plan_delay = 1;
    logic [31:0] plan_data = '0;
    logic [1:0]  plan_resp = '0;
    bit          em_owes = 0;
    int          em_due = 0;
    logic [31:0] em_data = '0;
    logic [1:0]  em_resp = '0;
    bit          f_up_req, f_dm_req, f_dm_rsp, f_up_rsp;

    function automatic bit e_dm_req_valid();
        return m_active && (m_req_op != 2'd3) && !m_issued && !m_stale;
    endfunction

    function automatic bit e_dm_rsp_ready();
        return (m_issued && !m_have_rsp) || m_stale;
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_active = 0; m_issued = 0; m_have_rsp = 0; m_stale = 0; m_tmo = 0;
            m_req_addr = '0; m_req_data = '0; m_req_op = '0;
            m_rsp_data = '0; m_rsp_resp = '0;
            em_owes = 0;
            dm_rsp_valid = 1'b0;
        end else begin
            cyc++;
            f_up_req = up_req_valid && !m_active;
            f_dm_req = e_dm_req_valid() && dm_req_ready;
            f_dm_rsp = dm_rsp_valid && e_dm_rsp_ready();
            f_up_rsp = m_have_rsp && up_rsp_ready;
            if (f_dm_rsp) em_owes = 0;
            if (f_dm_rsp && m_stale) begin
                m_stale = 0;
            end else if (f_dm_rsp) begin
                m_have_rsp = 1; m_rsp_data = dm_rsp_data; m_rsp_resp = dm_rsp_response;
            end else if (m_issued && !m_have_rsp && (cyc - m_issue_cyc == T)) begin
                m_have_rsp = 1; m_rsp_data = 32'd0; m_rsp_resp = 2'd2;
                m_stale = 1;
                m_tmo = (m_tmo < 65535) ? m_tmo + 1 : m_tmo;
            end
            if (f_dm_req) begin
                m_issued = 1; m_issue_cyc = cyc;
                em_owes = 1; em_due = cyc + plan_delay; em_data = plan_data; em_resp = plan_resp;
            end
            if (f_up_rsp) begin
                m_active = 0; m_have_rsp = 0; m_issued = 0;
            end
            if (f_up_req) begin
                m_active = 1; m_issued = 0;
                m_req_addr = up_req_addr; m_req_data = up_req_data; m_req_op = up_req_op;
                if (up_req_op == 2'd3) begin
                    m_have_rsp = 1; m_rsp_data = 32'd0; m_rsp_resp = 2'd2;
                end
            end
            #1;
            dm_rsp_valid    = em_owes && (cyc + 1 >= em_due);
            dm_rsp_data     = dm_rsp_valid ? em_data : $urandom();
            dm_rsp_response = dm_rsp_valid ? em_resp : 2'($urandom());
        end
    end

    always @(negedge CLK) begin
        if (chk_en && RST_N) begin
            chk("up_req_ready", 32'(up_req_ready), 32'(!m_active));
            chk("dm_req_valid", 32'(dm_req_valid), 32'(e_dm_req_valid()));
            chk("dm_rsp_ready", 32'(dm_rsp_ready), 32'(e_dm_rsp_ready()));
            chk("up_rsp_valid", 32'(up_rsp_valid), 32'(m_have_rsp));
            chk("busy", 32'(busy), 32'(m_active));
            chk("stale", 32'(stale), 32'(m_stale));
            chk("timeout_count", 32'(timeout_count), 32'(m_tmo));
            if (e_dm_req_valid()) begin
                chk("dm_req_addr", 32'(dm_req_addr), 32'(m_req_addr));
                chk("dm_req_data", dm_req_data, m_req_data);
                chk("dm_req_op", 32'(dm_req_op), 32'(m_req_op));
            end
            if (m_have_rsp) begin
                chk("up_rsp_data", up_rsp_data, m_rsp_data);
                chk("up_rsp_response", 32'(up_rsp_response), 32'(m_rsp_resp));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic set_plan(input int d, input logic [31:0] data, input logic [1:0] resp);
        plan_delay = d; plan_data = data; plan_resp = resp;
    endtask

    task automatic send(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        up_req_valid = 1'b1; up_req_addr = a; up_req_data = d; up_req_op = op;
        tick();
        up_req_valid = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_up_req_ready", 32'(up_req_ready), 32'd0);
        chk("rst_up_rsp_valid", 32'(up_rsp_valid), 32'd0);
        chk("rst_dm_req_valid", 32'(dm_req_valid), 32'd0);
        chk("rst_dm_rsp_ready", 32'(dm_rsp_ready), 32'd0);
        chk("rst_up_rsp_data", up_rsp_data, 32'd0);
        chk("rst_up_rsp_response", 32'(up_rsp_response), 32'd0);
        chk("rst_dm_req_addr", 32'(dm_req_addr), 32'd0);
        chk("rst_dm_req_data", dm_req_data, 32'd0);
        chk("rst_dm_req_op", 32'(dm_req_op), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stale", 32'(stale), 32'd0);
        chk("rst_timeout_count", 32'(timeout_count), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded its time budget (%0d compared, %0d mismatched)", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int drain_n;
        int r;
        #3;
        check_reset_vals();
        tick();
        tick();
        RST_N = 1'b1;
        #1 chk("rdy_after_release", 32'(up_req_ready), 32'd1);
        chk_en = 1'b1;

        // Read passthrough, zero backpressure.
        dm_req_ready = 1'b1; up_rsp_ready = 1'b1;
        set_plan(1, 32'h0000_3A2B, 2'd0);
        send(7'h11, 32'd0, 2'd1);
        chk("rd_dm_req_valid", 32'(dm_req_valid), 32'd1);
        chk("rd_dm_req_addr", 32'(dm_req_addr), 32'h11);
        chk("rd_dm_req_op", 32'(dm_req_op), 32'd1);
        tick();
        chk("rd_rsp_early", 32'(up_rsp_valid), 32'd0);
        tick();
        chk("rd_rsp_valid", 32'(up_rsp_valid), 32'd1);
        chk("rd_rsp_data", up_rsp_data, 32'h0000_3A2B);
        chk("rd_rsp_resp", 32'(up_rsp_response), 32'd0);
        tick();
        chk("rd_done_ready", 32'(up_req_ready), 32'd1);

        // Reserved op answered locally.
        send(7'h22, 32'h1234_5678, 2'd3);
        chk("rsvd_rsp_valid", 32'(up_rsp_valid), 32'd1);
        chk("rsvd_rsp_data", up_rsp_data, 32'd0);
        chk("rsvd_rsp_resp", 32'(up_rsp_response), 32'd2);
        chk("rsvd_no_dm_req", 32'(dm_req_valid), 32'd0);
        tick();
        chk("rsvd_done", 32'(busy), 32'd0);

        // Timeout, then a queued request held off until the late reply drains.
        set_plan(20, 32'h0000_DEAD, 2'd0);
        send(7'h05, 32'hCAFE_F00D, 2'd2);
        chk("wr_dm_req_data", dm_req_data, 32'hCAFE_F00D);
        tick();
        repeat (T - 1) tick();
        chk("tmo_not_yet", 32'(up_rsp_valid), 32'd0);
        tick();
        chk("tmo_rsp_valid", 32'(up_rsp_valid), 32'd1);
        chk("tmo_rsp_resp", 32'(up_rsp_response), 32'd2);
        chk("tmo_rsp_data", up_rsp_data, 32'd0);
        chk("tmo_stale", 32'(stale), 32'd1);
        chk("tmo_count", 32'(timeout_count), 32'd1);
        tick();
        set_plan(2, 32'h0000_55AA, 2'd0);
        send(7'h33, 32'd0, 2'd1);
        for (int i = 0; i < 10; i++) begin
            chk("stale_hold_req", 32'(dm_req_valid), 32'd0);
            chk("stale_hold_flag", 32'(stale), 32'd1);
            tick();
        end
        chk("drain_stale_clr", 32'(stale), 32'd0);
        chk("drain_no_leak", 32'(up_rsp_valid), 32'd0);
        chk("drain_req_go", 32'(dm_req_valid), 32'd1);
        tick();
        tick();
        tick();
        chk("queued_rsp_valid", 32'(up_rsp_valid), 32'd1);
        chk("queued_rsp_data", up_rsp_data, 32'h0000_55AA);
        tick();

        // Backpressure on both sides; ISSUE is held longer than the timeout.
        dm_req_ready = 1'b0; up_rsp_ready = 1'b0;
        set_plan(3, 32'h1234_5678, 2'd3);
        send(7'h44, 32'h0000_0001, 2'd1);
        repeat (12) begin
            chk("bp_req_valid", 32'(dm_req_valid), 32'd1);
            chk("bp_req_addr", 32'(dm_req_addr), 32'h44);
            chk("bp_req_data", dm_req_data, 32'h0000_0001);
            tick();
        end
        dm_req_ready = 1'b1;
        tick();
        chk("bp_no_issue_tmo", 32'(timeout_count), 32'd1);
        tick();
        tick();
        chk("bp_rsp_early", 32'(up_rsp_valid), 32'd0);
        tick();
        repeat (4) begin
            chk("bp_rsp_valid", 32'(up_rsp_valid), 32'd1);
            chk("bp_rsp_data", up_rsp_data, 32'h1234_5678);
            chk("bp_rsp_resp", 32'(up_rsp_response), 32'd3);
            tick();
        end
        chk("bp_rsp_still", 32'(up_rsp_valid), 32'd1);
        up_rsp_ready = 1'b1;
        tick();
        chk("bp_rsp_taken", 32'(up_rsp_valid), 32'd0);

        // Reply on exactly the timeout edge wins.
        set_plan(T, 32'hBEEF_0001, 2'd0);
        send(7'h66, 32'd0, 2'd1);
        tick();
        repeat (T - 1) tick();
        chk("tie_not_yet", 32'(up_rsp_valid), 32'd0);
        tick();
        chk("tie_rsp_valid", 32'(up_rsp_valid), 32'd1);
        chk("tie_rsp_data", up_rsp_data, 32'hBEEF_0001);
        chk("tie_rsp_resp", 32'(up_rsp_response), 32'd0);
        chk("tie_stale", 32'(stale), 32'd0);
        chk("tie_count", 32'(timeout_count), 32'd1);
        tick();

        // Asynchronous reset while waiting on the debug module.
        set_plan(6, 32'h0000_9999, 2'd0);
        send(7'h77, 32'd0, 2'd1);
        tick();
        tick();
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_wait_ready", 32'(dm_rsp_ready), 32'd1);
        #1 RST_N = 1'b0;
        #1 check_reset_vals();
        tick();
        tick();
        RST_N = 1'b1;
        #1 chk("mid_rdy_release", 32'(up_req_ready), 32'd1);
        set_plan(1, 32'h0BAD_F00D, 2'd0);
        send(7'h08, 32'd0, 2'd1);
        tick();
        tick();
        chk("post_rst_rsp_valid", 32'(up_rsp_valid), 32'd1);
        chk("post_rst_rsp_data", up_rsp_data, 32'h0BAD_F00D);
        tick();
        chk("post_rst_idle", 32'(busy), 32'd0);

        // Random traffic, including ties and late replies.
        for (int i = 0; i < 3000; i++) begin
            up_req_valid = ($urandom_range(0, 9) < 6);
            up_req_addr  = 7'($urandom());
            up_req_data  = $urandom();
            up_req_op    = ($urandom_range(0, 9) < 2) ? 2'd3 : 2'($urandom_range(0, 2));
            up_rsp_ready = ($urandom_range(0, 9) < 7);
            dm_req_ready = ($urandom_range(0, 9) < 6);
            r = int'($urandom_range(0, 19));
            if (r < 12)      plan_delay = int'($urandom_range(1, T - 1));
            else if (r < 15) plan_delay = T;
            else             plan_delay = int'($urandom_range(T + 1, 30));
            plan_data = $urandom();
            plan_resp = 2'($urandom());
            tick();
        end

        up_req_valid = 1'b0; up_rsp_ready = 1'b1; dm_req_ready = 1'b1;
        set_plan(1, 32'h0, 2'd0);
        drain_n = 0;
        while ((m_active || m_stale || em_owes) && drain_n < 200) begin
            tick();
            drain_n++;
        end
        chk("final_busy", 32'(busy), 32'd0);
        chk("final_stale", 32'(stale), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
